// File: rtl/bypass_bin_scheduler_pkg.sv
// Shared definitions for the CABAC bypass bin scheduler.
//   state_e               : controller states (IDLE, RUN, DONE)
//   BYPASS_BINS_PER_CYCLE : bins resolved per cycle by the DecodeBinEP datapath
//   BITS_NEEDED_RELOAD    : bits_needed adjustment when a byte is inserted (-8)
package bypass_bin_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned      BYPASS_BINS_PER_CYCLE = 3;
  localparam logic signed [3:0] BITS_NEEDED_RELOAD   = 4'sb1000; // -8

endpackage

// File: rtl/bypass_refill_ctl.sv
// Refill point locator for one bypass chunk (purely combinational).
//   bits_need_i  : signed bits_needed at chunk start (-8..-1)
//   k_i          : bins in this chunk (0..3)
//   byte_valid_i : bitstream byte available
//   byte_data_i  : bitstream byte
//   shift0_i..2  : datapath value_shifted_out per stage
//   refill_o     : a stage of this chunk needs a byte
//   stall_o      : byte needed but not available
//   bits_next_o  : bits_needed after the chunk
//   new0_o..2    : shiftN with the byte added at the refill stage
module bypass_refill_ctl
  import bypass_bin_scheduler_pkg::*;
(
  input  logic signed [3:0] bits_need_i,
  input  logic [1:0]        k_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  input  logic [16:0]       shift0_i,
  input  logic [16:0]       shift1_i,
  input  logic [16:0]       shift2_i,
  output logic              refill_o,
  output logic              stall_o,
  output logic signed [3:0] bits_next_o,
  output logic [16:0]       new0_o,
  output logic [16:0]       new1_o,
  output logic [16:0]       new2_o
);

  // Stage i refills when bits_need + i + 1 == 0, i.e. i == ~bits_need.
  logic [3:0]  need;
  logic [1:0]  stage;
  logic [16:0] byte_ext;

  assign need     = ~bits_need_i;
  assign stage    = need[1:0];
  assign refill_o = need < {2'b00, k_i};
  assign stall_o  = refill_o & ~byte_valid_i;
  assign byte_ext = {9'b0, byte_data_i};

  assign bits_next_o = bits_need_i + $signed({2'b00, k_i})
                     + (refill_o ? BITS_NEEDED_RELOAD : 4'sb0000);

  // Separate assigns per stage: each newN feeds the datapath which produces
  // shift(N+1), so they must not share one combinational process.
  assign new0_o = shift0_i + ((refill_o && stage == 2'd0) ? byte_ext : '0);
  assign new1_o = shift1_i + ((refill_o && stage == 2'd1) ? byte_ext : '0);
  assign new2_o = shift2_i + ((refill_o && stage == 2'd2) ? byte_ext : '0);

endmodule

// File: rtl/bypass_bin_scheduler.sv
// Multi-bin CABAC bypass sequencer around one 3-bin/cycle DecodeBinEP.
//   req_*   : request (num_bins, range, value, bits_needed), valid/ready
//   byte_*  : bitstream byte FIFO, byte_ready is the pop strobe
//   rsp_*   : packed bins (first bin MSB of used field), final value/bits
//   ep_*    : drive/observe the external DecodeBinEP datapath
module bypass_bin_scheduler
  import bypass_bin_scheduler_pkg::*;
#(
  parameter int unsigned MAX_BINS = 32,
  parameter int unsigned CNT_W    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CNT_W-1:0]    req_num_bins,
  input  logic [8:0]          req_range,
  input  logic [15:0]         req_value,
  input  logic signed [3:0]   req_bits_need,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                byte_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [MAX_BINS-1:0] rsp_bins,
  output logic [15:0]         rsp_value,
  output logic signed [3:0]   rsp_bits_need,
  output logic [8:0]          ep_m_range,
  output logic [15:0]         ep_m_value,
  output logic [1:0]          ep_n_bin,
  input  logic [16:0]         ep_shift0,
  input  logic [16:0]         ep_shift1,
  input  logic [16:0]         ep_shift2,
  output logic [16:0]         ep_new0,
  output logic [16:0]         ep_new1,
  output logic [16:0]         ep_new2,
  input  logic [2:0]          ep_bins,
  input  logic [15:0]         ep_value_out
);

  state_e                state_q, state_d;
  logic [8:0]            range_q, range_d;
  logic [15:0]           value_q, value_d;
  logic signed [3:0]     bits_q, bits_d;
  logic [CNT_W-1:0]      rem_q, rem_d;
  logic [MAX_BINS-1:0]   bins_q, bins_d;

  logic [1:0]            k;
  logic [CNT_W-1:0]      k_ext;
  logic                  refill, stall, accept, advance;
  logic signed [3:0]     bits_next;
  logic [2:0]            ord;

  assign k = (rem_q >= CNT_W'(BYPASS_BINS_PER_CYCLE)) ? 2'(BYPASS_BINS_PER_CYCLE) : rem_q[1:0];
  assign k_ext   = {{(CNT_W-2){1'b0}}, k};
  assign accept  = req_valid & req_ready;
  assign advance = (state_q == RUN) & ~stall;

  bypass_refill_ctl u_refill (
    .bits_need_i  (bits_q),
    .k_i          (k),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .shift0_i     (ep_shift0),
    .shift1_i     (ep_shift1),
    .shift2_i     (ep_shift2),
    .refill_o     (refill),
    .stall_o      (stall),
    .bits_next_o  (bits_next),
    .new0_o       (ep_new0),
    .new1_o       (ep_new1),
    .new2_o       (ep_new2)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state (last chunk is the one where remaining == k)
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (advance && rem_q == k_ext) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    byte_ready = 1'b0;
    ep_n_bin   = 2'd0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      RUN: begin
        ep_n_bin   = k - 2'd1;
        byte_ready = refill & byte_valid;
      end
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Bins arrive stage0 at bit 0; repack so stage0 is most significant.
  always_comb begin
    case (k)
      2'd1:    ord = {2'b00, ep_bins[0]};
      2'd2:    ord = {1'b0, ep_bins[0], ep_bins[1]};
      default: ord = {ep_bins[0], ep_bins[1], ep_bins[2]};
    endcase
  end

  always_comb begin
    range_d = range_q;
    value_d = value_q;
    bits_d  = bits_q;
    rem_d   = rem_q;
    bins_d  = bins_q;
    if (accept) begin
      range_d = req_range;
      value_d = req_value;
      bits_d  = req_bits_need;
      rem_d   = req_num_bins;
      bins_d  = '0;
    end else if (advance) begin
      value_d = ep_value_out;
      bits_d  = bits_next;
      rem_d   = rem_q - k_ext;
      bins_d  = (bins_q << k) | MAX_BINS'(ord);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_q <= '0;
      value_q <= '0;
      bits_q  <= '0;
      rem_q   <= '0;
      bins_q  <= '0;
    end else begin
      range_q <= range_d;
      value_q <= value_d;
      bits_q  <= bits_d;
      rem_q   <= rem_d;
      bins_q  <= bins_d;
    end
  end

  assign rsp_bins      = bins_q;
  assign rsp_value     = value_q;
  assign rsp_bits_need = bits_q;
  assign ep_m_range    = range_q;
  assign ep_m_value    = value_q;

  a_legal_num_bins: assert property (@(posedge clk) disable iff (!rst_n)
    (req_valid && req_ready) |-> (req_num_bins != '0 && int'(req_num_bins) <= int'(MAX_BINS)));

endmodule

// File: tb/tb_bypass_bin_scheduler.sv
module tb_bypass_bin_scheduler;

  localparam int MAXB = 32;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [5:0]  req_num_bins;
  logic [8:0]  req_range;
  logic [15:0] req_value;
  logic [3:0]  req_bits_need;
  logic        byte_valid, byte_ready;
  logic [7:0]  byte_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_bins;
  logic [15:0] rsp_value;
  logic [3:0]  rsp_bits_need;
  logic [8:0]  ep_m_range;
  logic [15:0] ep_m_value;
  logic [1:0]  ep_n_bin;
  logic [16:0] ep_shift0, ep_shift1, ep_shift2;
  logic [16:0] ep_new0, ep_new1, ep_new2;
  logic [2:0]  ep_bins;
  logic [15:0] ep_value_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  bytes [8];
  bit          refill_at [MAXB];
  logic [15:0] trace_val [MAXB+1];

  bypass_bin_scheduler #(.MAX_BINS(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_num_bins(req_num_bins),
    .req_range(req_range), .req_value(req_value), .req_bits_need(req_bits_need),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bins(rsp_bins),
    .rsp_value(rsp_value), .rsp_bits_need(rsp_bits_need),
    .ep_m_range(ep_m_range), .ep_m_value(ep_m_value), .ep_n_bin(ep_n_bin),
    .ep_shift0(ep_shift0), .ep_shift1(ep_shift1), .ep_shift2(ep_shift2),
    .ep_new0(ep_new0), .ep_new1(ep_new1), .ep_new2(ep_new2),
    .ep_bins(ep_bins), .ep_value_out(ep_value_out)
  );

  // DecodeBinEP datapath: shift, (refill added by DUT), compare/subtract.
  logic [15:0] scaled;
  logic        b0, b1, b2;
  logic [15:0] v0, v1, v2;
  assign scaled       = {ep_m_range, 7'b0};
  assign ep_shift0    = {ep_m_value, 1'b0};
  assign b0           = ep_new0 >= {1'b0, scaled};
  assign v0           = ep_new0[15:0] - (b0 ? scaled : 16'h0);
  assign ep_shift1    = {v0, 1'b0};
  assign b1           = ep_new1 >= {1'b0, scaled};
  assign v1           = ep_new1[15:0] - (b1 ? scaled : 16'h0);
  assign ep_shift2    = {v1, 1'b0};
  assign b2           = ep_new2 >= {1'b0, scaled};
  assign v2           = ep_new2[15:0] - (b2 ? scaled : 16'h0);
  assign ep_bins      = {b2, b1, b0};
  assign ep_value_out = (ep_n_bin == 2'd0) ? v0 : (ep_n_bin == 2'd1) ? v1 : v2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bin-by-bin reference of the VTM bypass decode loop.
  task automatic golden(input int rng, input int val, input int bits, input int n,
                        output logic [31:0] eb, output int ev, output int ebits, output int pops);
    int v, b, sc;
    eb = 32'h0; v = val; b = bits; pops = 0; sc = rng * 128;
    trace_val[0] = 16'(val);
    for (int j = 0; j < n; j++) begin
      v = (v * 2) & 'h1FFFF;
      b++;
      refill_at[j] = 1'b0;
      if (b >= 0) begin
        b = -8;
        v = (v + int'(bytes[pops])) & 'h1FFFF;
        pops++;
        refill_at[j] = 1'b1;
      end
      eb = eb << 1;
      if (v >= sc) begin
        eb[0] = 1'b1;
        v = v - sc;
      end
      v = v & 'hFFFF;
      trace_val[j+1] = 16'(v);
    end
    ev = v; ebits = b;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_req_ready"},  32'(req_ready),     32'd1);
    check_eq({pfx, "_rsp_valid"},  32'(rsp_valid),     32'd0);
    check_eq({pfx, "_byte_ready"}, 32'(byte_ready),    32'd0);
    check_eq({pfx, "_rsp_bins"},   rsp_bins,           32'd0);
    check_eq({pfx, "_rsp_value"},  32'(rsp_value),     32'd0);
    check_eq({pfx, "_rsp_bits"},   32'(rsp_bits_need), 32'd0);
    check_eq({pfx, "_ep_n_bin"},   32'(ep_n_bin),      32'd0);
    check_eq({pfx, "_ep_m_value"}, 32'(ep_m_value),    32'd0);
  endtask

  task automatic run_req(input int rng, input int val, input int bits, input int n,
                         input int stall, input int drop, input int hold, input int fixed_byte);
    logic [31:0] eb;
    int ev, ebits, pops, done, idx, stall_left, k;
    bit refill, fin;
    for (int i = 0; i < 8; i++) bytes[i] = (fixed_byte >= 0) ? 8'(fixed_byte) : 8'($urandom);
    golden(rng, val, bits, n, eb, ev, ebits, pops);
    @(negedge clk);
    req_valid = 1'b1; req_range = 9'(rng); req_value = 16'(val);
    req_bits_need = 4'(bits); req_num_bins = 6'(n); byte_valid = 1'b0;
    #1 check_eq("accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    done = 0; idx = 0; stall_left = stall; fin = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (done == n) begin
        byte_valid = 1'b0;
        #1 check_eq("rsp_valid_rise", 32'(rsp_valid), 32'd1);
        fin = 1'b1;
      end else begin
        k = (n - done < 3) ? n - done : 3;
        refill = 1'b0;
        for (int j = done; j < done + k; j++) if (refill_at[j]) refill = 1'b1;
        if (refill && stall_left > 0) begin
          byte_valid = 1'b0;
          stall_left--;
        end else begin
          byte_valid = ($urandom_range(0, 99) >= drop);
        end
        byte_data = bytes[idx];
        #1;
        check_eq("rsp_valid_early", 32'(rsp_valid), 32'd0);
        check_eq("ep_n_bin", 32'(ep_n_bin), 32'(k - 1));
        check_eq("ep_m_value", 32'(ep_m_value), 32'(trace_val[done]));
        check_eq("ep_m_range", 32'(ep_m_range), 32'(rng));
        if (refill && !byte_valid) begin
          check_eq("stall_pop", 32'(byte_ready), 32'd0);
        end else begin
          check_eq("byte_ready", 32'(byte_ready), 32'(refill));
          if (refill) idx++;
          done += k;
        end
      end
    end
    if (!fin) check_eq("rsp_timeout", 32'd0, 32'd1);
    check_eq("rsp_bins", rsp_bins, eb);
    check_eq("rsp_value", 32'(rsp_value), 32'(ev));
    check_eq("rsp_bits_need", 32'(rsp_bits_need), 32'(ebits & 15));
    check_eq("bytes_popped", 32'(idx), 32'(pops));
    rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      #1;
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_bins", rsp_bins, eb);
      check_eq("hold_value", 32'(rsp_value), 32'(ev));
      check_eq("hold_req_ready", 32'(req_ready), 32'd0);
      check_eq("hold_byte_ready", 32'(byte_ready), 32'd0);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int rng;
    rst_n = 1'b0; req_valid = 1'b0; req_num_bins = '0; req_range = '0; req_value = '0;
    req_bits_need = '0; byte_valid = 1'b0; byte_data = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed cases.
    run_req(256, 'h4000, -8, 1, 0, 0, 0, -1);
    check_eq("d1_bins", rsp_bins, 32'h1);
    run_req(256, 'h7FFF, -8, 3, 0, 0, 0, -1);
    check_eq("d2_value", 32'(rsp_value), 32'h7FF8);
    run_req(256, 'h0000, -1, 1, 0, 0, 0, 'hFF);
    check_eq("d3_value", 32'(rsp_value), 32'h00FF);
    run_req(256, 'h0000, -1, 1, 4, 0, 0, 'hFF);
    check_eq("d4_bits", 32'(rsp_bits_need), 32'h8);
    run_req(256, int'($urandom_range(0, 'h7FFF)), -8, 32, 0, 0, 5, -1);

    // Randomized requests with byte starvation and response backpressure.
    for (int t = 0; t < 30; t++) begin
      rng = int'($urandom_range(256, 510));
      run_req(rng, int'($urandom_range(0, rng * 128 - 1)), -int'($urandom_range(1, 8)),
              int'($urandom_range(1, 32)), int'($urandom_range(0, 3)), 30,
              int'($urandom_range(0, 3)), -1);
    end

    // Reset in the middle of a long run.
    for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom);
    @(negedge clk);
    req_valid = 1'b1; req_range = 9'd300; req_value = 16'h1234;
    req_bits_need = 4'hD; req_num_bins = 6'd32;
    @(negedge clk);
    req_valid = 1'b0; byte_valid = 1'b1; byte_data = bytes[0];
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrun");
    @(negedge clk);
    rst_n = 1'b1; byte_valid = 1'b0;
    run_req(256, 'h4000, -8, 1, 0, 0, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
